tone_decoder: RTL
=================

Name: tone_decoder

Overview:
- Recovers the note being played from an incoming square-wave tone (speaker loopback or microphone comparator) by measuring its period in system clocks.
- Outputs the matching note index, the LED digit code and an octave-high flag.
- Inverse of the note-to-tone generation path; drives the same LED/"high" indicators so a bench can close the loop.

Parameters:
- CLK_HZ, 1000000, system clock frequency; the period table is defined for this value.
- STABLE_N, 3, consecutive matching periods required before a note is reported.
- TIMEOUT, 16'd8000, cycles without a rising edge before declaring silence.
- TOL_SHIFT, 6, match tolerance = table_period >> TOL_SHIFT (about ±1.6%).

Ports:
- clk  in  1  system clock (1 MHz)
- rst_n  in  1  asynchronous active-low reset
- tone_in  in  1  asynchronous square-wave input
- note  out  4  matched note index; 0 = silence/none
- code  out  4  LED digit 1..7 for the note; 0 for silence
- high  out  1  1 when note >= 8
- note_valid  out  1  one-cycle pulse when the reported note changes
- locked  out  1  level; 1 while a note is reported

Behaviour:
- Reset (asynchronous, active-low): note = 0, code = 0, high = 0, note_valid = 0, locked = 0, state = SILENT; all counters and synchronisers cleared.
- Input conditioning:
  - tone_in passes through a 2-FF synchroniser, then a registered rising-edge detect.
  - Edge-pulse latency is 3 clk after the input edge.
- Period counter:
  - 16 bits; increments every clk and saturates at 16'hFFFF.
  - On an edge pulse, its value + 1 is latched into per_q and the counter restarts at 0.
  - If the counter reaches TIMEOUT, a silence event fires.
- Period table, in cycles at 1 MHz:
  - idx 1..7: 3817, 3401, 3030, 2865, 2551, 2273, 2024
  - idx 8..15: 1912, 1704, 1517, 1433, 1276, 1136, 1012, 956
- FSM states SILENT, SEARCH, LOCKED:
  - SEARCH begins on each edge pulse, once the first edge after SILENT has seeded the counter.
  - The search scans idx 1..15, one entry per clk (15 cycles, always shorter than the minimum period).
  - Match condition: |per_q − P[idx]| <= P[idx] >> TOL_SHIFT. The first match wins; no match gives cand = 0.
  - After the scan: if cand equals prev_cand and is nonzero, run_cnt increments (saturating at STABLE_N); otherwise run_cnt = 1 and prev_cand = cand.
  - When run_cnt reaches STABLE_N and cand differs from the reported note: update note/code/high, pulse note_valid for one cycle, set locked = 1, go to LOCKED.
  - From LOCKED, a different stable candidate produces the same update plus a pulse (no intermediate 0).
  - An unmatched period (cand = 0) resets run_cnt but leaves the reported note held.
- code = ((note − 1) mod 7) + 1 for note 1..14; code = 1 for note 15; code = 0 for note 0. high = (note >= 8).
- Silence event from any state:
  - note = 0, code = 0, high = 0, locked = 0, run_cnt = 0, state = SILENT.
  - note_valid pulses only if the previously reported note was nonzero.
- Simultaneous edge pulse and timeout: the edge wins and the counter restarts.
- An edge pulse arriving during an active scan (period < 16 cycles, a glitch): the scan is aborted, the candidate is discarded, and run_cnt resets.
- Reset asserted mid-search: everything returns to reset values immediately; no note_valid pulse.

Optional Feature:
- Macro TONE_DEC_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter follows the synchroniser; edge latency becomes 5 clk; single-cycle input pulses are rejected.
- Undefined: no filter; latency 3 clk; any synchronised pulse counts as an edge.

Test Plan:
- Reset, then tone_in held low for 10000 cycles -> note = 0, locked = 0, no note_valid pulse.
- 440 Hz square wave (period 2273) -> after the 3rd full period, note = 6, code = 6, high = 0, locked = 1, a single note_valid pulse.
- 784 Hz then switch to 262 Hz -> note 12 (code 5, high 1), then note 1 (code 1, high 0); exactly one pulse at each change, no intermediate 0.
- 440 Hz locked, then input stops -> TIMEOUT cycles after the last edge: note = 0, locked = 0, one note_valid pulse.
- Alternating periods 2273/3000 (never STABLE_N equal) -> no lock, note stays 0; period 2400 (no table match) -> no lock.
- With TONE_DEC_GLITCH_FILTER_EN: 440 Hz plus 1-cycle spikes mid-period -> still locks to note 6; without the macro, the spikes cause no lock.

Source files
------------

// File: rtl/tone_decoder.sv
// Tone decoder: measures the period of a square-wave input in clocks and reports the matching note.
// Optional 3-sample majority glitch filter after the synchroniser: define TONE_DEC_GLITCH_FILTER_EN.
module tone_decoder #(
  parameter int          CLK_HZ    = 1000000,
  parameter int          STABLE_N  = 3,
  parameter logic [15:0] TIMEOUT   = 16'd8000,
  parameter int          TOL_SHIFT = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tone_in,
  output logic [3:0] note,
  output logic [3:0] code,
  output logic       high,
  output logic       note_valid,
  output logic       locked
);

  localparam int               RUN_W   = $clog2(STABLE_N + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_N);

  typedef enum logic [1:0] {SILENT, SEARCH, LOCKED} state_t;

  function automatic logic [15:0] period_of(input logic [3:0] idx);
    int base;
    case (idx)
      4'd1:    base = 3817;
      4'd2:    base = 3401;
      4'd3:    base = 3030;
      4'd4:    base = 2865;
      4'd5:    base = 2551;
      4'd6:    base = 2273;
      4'd7:    base = 2024;
      4'd8:    base = 1912;
      4'd9:    base = 1704;
      4'd10:   base = 1517;
      4'd11:   base = 1433;
      4'd12:   base = 1276;
      4'd13:   base = 1136;
      4'd14:   base = 1012;
      4'd15:   base = 956;
      default: base = 0;
    endcase
    return 16'((base * (CLK_HZ / 1000)) / 1000);
  endfunction

  function automatic logic period_match(input logic [15:0] per, input logic [3:0] idx);
    logic [15:0]        p;
    logic signed [16:0] diff;
    logic [15:0]        mag;
    p    = period_of(idx);
    diff = $signed({1'b0, per}) - $signed({1'b0, p});
    mag  = diff[16] ? 16'(-diff) : diff[15:0];
    return (p != 16'd0) && (mag <= (p >> TOL_SHIFT));
  endfunction

  function automatic logic [3:0] code_of(input logic [3:0] n);
    int k;
    if (n == 4'd0) return 4'd0;
    k = ((int'(n) - 1) % 7) + 1;
    return 4'(k);
  endfunction

  logic s1_q, s2_q, lvl, lvl_prev_q, edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= tone_in;
      s2_q <= s1_q;
    end
  end

`ifdef TONE_DEC_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       maj_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b00;
      maj_q  <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], s2_q};
      maj_q  <= (s2_q & hist_q[0]) | (s2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign lvl = maj_q;
`else
  assign lvl = s2_q;
`endif

  // Stage: rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_prev_q <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      lvl_prev_q <= lvl;
      edge_q     <= lvl & ~lvl_prev_q;
    end
  end

  logic [15:0] cnt_q, per_q;
  logic        timeout_ev;

  // Edge beats timeout when both land on the same cycle.
  assign timeout_ev = !edge_q && (cnt_q == TIMEOUT);

  // Stage: period counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
      per_q <= 16'd0;
    end else if (edge_q) begin
      cnt_q <= 16'd0;
      per_q <= cnt_q + 16'd1;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  state_t           state_q, state_d;
  logic [3:0]       idx_q, cand_q, prevc_q, note_q, cand_f;
  logic [RUN_W-1:0] run_q, run_next;
  logic             seeded_q, nv_q, scan_done, same_cand, upd;

  always_comb begin
    cand_f = cand_q;
    if (cand_q == 4'd0 && period_match(per_q, idx_q)) cand_f = idx_q;
    same_cand = (cand_f != 4'd0) && (cand_f == prevc_q);
    run_next  = RUN_W'(1);
    if (same_cand) run_next = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    scan_done = (state_q == SEARCH) && (idx_q == 4'd15) && !edge_q && !timeout_ev;
    upd       = scan_done && (run_next == RUN_MAX) && (cand_f != 4'd0) && (cand_f != note_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SILENT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout_ev)
      state_d = SILENT;
    else if (edge_q && (seeded_q || state_q != SILENT))
      state_d = SEARCH;
    else if (scan_done)
      state_d = (upd || note_q != 4'd0) ? LOCKED : SILENT;
  end

  // Stage: table scan and stability tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= 4'd1;
      cand_q   <= 4'd0;
      prevc_q  <= 4'd0;
      note_q   <= 4'd0;
      run_q    <= '0;
      seeded_q <= 1'b0;
      nv_q     <= 1'b0;
    end else begin
      nv_q <= 1'b0;
      if (timeout_ev) begin
        note_q   <= 4'd0;
        run_q    <= '0;
        prevc_q  <= 4'd0;
        cand_q   <= 4'd0;
        idx_q    <= 4'd1;
        seeded_q <= 1'b0;
        nv_q     <= (note_q != 4'd0);
      end else if (edge_q) begin
        seeded_q <= 1'b1;
        idx_q    <= 4'd1;
        cand_q   <= 4'd0;
        if (state_q == SEARCH) begin
          run_q   <= '0;
          prevc_q <= 4'd0;
        end
      end else if (state_q == SEARCH) begin
        cand_q <= cand_f;
        idx_q  <= idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          run_q   <= run_next;
          prevc_q <= cand_f;
          if (upd) begin
            note_q <= cand_f;
            nv_q   <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    note       = note_q;
    code       = code_of(note_q);
    high       = note_q[3];
    note_valid = nv_q;
    locked     = (note_q != 4'd0);
  end

endmodule
